spi_slave_regfile: RTL and testbench
====================================

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
- NADDRBITS, 3, register address width; register count is 2^NADDRBITS.
- NDATABITS, 16, register width.
- INVERT_CLOCK, 1'b0, 0: sample mosi on sclk rise and shift miso on fall; 1: the reverse.
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
- clk, in, 1, single system clock for all logic.
- rst_n, in, 1, asynchronous active-low reset.
- sclk, in, 1, SPI clock; asynchronous to clk.
- cs_n, in, 1, active-low chip select; asynchronous.
- mosi, in, 1, serial data in, MSB first.
- miso, out, 1, serial data out, MSB first.
- miso_oe, out, 1, miso output enable.
- regs_o, out, 2^NADDRBITS*NDATABITS, flat register image; reg k occupies bits [k*NDATABITS +: NDATABITS].
- wr_stb_o, out, 1, one-clk pulse when a register is written.
- wr_addr_o, out, NADDRBITS, index of the register written.
- frame_cnt_o, out, 16, count of completed frames; wraps.

Function
REQ-003 Frame length SHALL be FLEN = 8+NDATABITS bits (24 at default): bit[FLEN-1] = RNW (1=read), bits[FLEN-2:NDATABITS] = 7-bit address, bits[NDATABITS-1:0] = data.
REQ-004 sclk, cs_n and mosi SHALL each pass a 2-flop synchronizer; sclk edges SHALL be detected from the synchronized signal; the clk frequency SHALL be at least 8x the sclk frequency.
REQ-005 A synchronized cs_n falling edge SHALL clear the bit counter and shift register and enter state SHIFT; states SHALL be IDLE, SHIFT, DONE.
REQ-006 Each sample edge in SHIFT SHALL shift the synchronized mosi into the LSB and increment the bit counter.
REQ-007 After the 8th sample edge: if RNW=1, the addressed register SHALL be loaded into the output shift register, miso_oe SHALL assert, and miso SHALL present the data MSB on the next shift edge, continuing MSB first.
REQ-008 Read of an address >= 2^NADDRBITS SHALL return all zeros.
REQ-009 On the FLEN-th sample edge the FSM SHALL enter DONE. For a write (RNW=0) with address < 2^NADDRBITS, the register SHALL update and wr_stb_o/wr_addr_o SHALL assert exactly 1 clk after the edge-detect cycle. frame_cnt_o SHALL increment by 1 for reads and writes.
REQ-010 A write to an out-of-range address SHALL not change any register and SHALL not pulse wr_stb_o; frame_cnt_o SHALL still increment.
REQ-011 cs_n rising before FLEN bits SHALL abort the frame: no write, no strobe, no count, return to IDLE.
REQ-012 Sample edges in DONE (more than FLEN bits) SHALL be ignored, with miso driven 0.
REQ-013 cs_n rising SHALL return the FSM to IDLE and deassert miso_oe within 1 clk; a commit already detected SHALL complete.
REQ-014 When miso_oe=0, miso SHALL be 0.

Reset
REQ-015 rst_n low SHALL immediately clear all registers, regs_o, frame_cnt_o, miso, miso_oe and wr_stb_o to 0 and put the FSM in IDLE; a frame in progress SHALL be discarded.
REQ-016 After rst_n release, a frame SHALL begin only on a new cs_n falling edge; if cs_n is already low, the module SHALL wait for cs_n to go high first.

Structure
REQ-017 Package spi_slave_pkg SHALL hold the FSM state enum, the FLEN function/constant, and the RNW and address field positions.
REQ-018 Sub-module spi_slave_sync SHALL implement the synchronizer plus rise/fall edge detect, instantiated once per input.

Verification
REQ-019 Write frame 0x03_ABCD -> regs_o[63:48]=0xABCD; exactly one wr_stb_o pulse with wr_addr_o=3; frame_cnt_o=1.
REQ-020 After REQ-019, read frame 0x83_0000 -> miso bits 8..23 = 0xABCD; miso_oe high from bit 8 until cs_n rises; no write.
REQ-021 cs_n raised after 20 bits of write 0x01_1234 -> reg1 unchanged; no strobe; frame_cnt_o unchanged.
REQ-022 Write 0x10_FFFF (out of range), then read 0x90_0000 -> no register changes; read returns 0x0000; frame_cnt_o increments by 2.
REQ-023 rst_n asserted at bit 12 of a write -> all outputs 0 at once; that frame commits nothing; the next full frame works.
REQ-024 INVERT_CLOCK=1 with sclk = clk/8 and 30 clocked bits -> first 24 bits commit, last 6 ignored, miso=0 after bit 24.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave register file: FSM states, frame geometry
// and field positions inside a frame.
package spi_slave_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned CMD_BITS     = 8;
  localparam int unsigned ADDR_FIELD_W = 7;

  function automatic int unsigned frame_len(input int unsigned ndatabits);
    return CMD_BITS + ndatabits;
  endfunction

  function automatic int unsigned rnw_pos(input int unsigned ndatabits);
    return frame_len(ndatabits) - 1;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned ndatabits);
    return ndatabits;
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_FIELD_W-1:0] a,
                                         input int unsigned naddrbits);
    return (32'(a) >> naddrbits) == 32'd0;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for one asynchronous input with rise/fall detection
// on the synchronized level.
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
      q_d    <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
      q_d    <= q;
    end
  end

  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave with a small register file: 8-bit command (RNW + address) followed
// by a data word; everything runs in the clk domain from synchronized inputs.
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int unsigned NADDRBITS    = 3,
  parameter int unsigned NDATABITS    = 16,
  parameter logic        INVERT_CLOCK = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sclk,
  input  logic                                 cs_n,
  input  logic                                 mosi,
  output logic                                 miso,
  output logic                                 miso_oe,
  output logic [(2**NADDRBITS)*NDATABITS-1:0]  regs_o,
  output logic                                 wr_stb_o,
  output logic [NADDRBITS-1:0]                 wr_addr_o,
  output logic [15:0]                          frame_cnt_o
);

  localparam int unsigned NREGS    = 2**NADDRBITS;
  localparam int unsigned FLEN     = frame_len(NDATABITS);
  localparam int unsigned CNTW     = $clog2(FLEN + 1);
  localparam int unsigned RNW_BIT  = rnw_pos(NDATABITS);
  localparam int unsigned ADDR_LSB = addr_lsb(NDATABITS);

  logic sclk_lvl_unused, sclk_rise_c, sclk_fall_c;
  logic cs_lvl_unused, cs_rise_c, cs_fall_c;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  logic [1:0]           state, state_d;
  logic [CNTW-1:0]      bit_cnt;
  logic [FLEN-2:0]      shreg;
  logic [NDATABITS-1:0] out_sr;
  logic [NDATABITS-1:0] regs_q [NREGS];

  logic                    sample_edge_c, shift_edge_c;
  logic [FLEN-1:0]         shift_nxt_c;
  logic [ADDR_FIELD_W-1:0] rd_addr_c, wr_addr_c;
  logic [NDATABITS-1:0]    rd_data_c;
  logic start_c, stop_c, sample_c, shift_c, load_c, last_c, write_c;

  spi_slave_sync #(.RST_VAL(INVERT_CLOCK)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(sclk_lvl_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  // cs_n resets low so a select already active at reset release must rise before a frame starts
  spi_slave_sync #(.RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n),
    .q(cs_lvl_unused), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi),
    .q(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  assign sample_edge_c = INVERT_CLOCK ? sclk_fall_c : sclk_rise_c;
  assign shift_edge_c  = INVERT_CLOCK ? sclk_rise_c : sclk_fall_c;
  assign shift_nxt_c   = {shreg, mosi_s};
  assign rd_addr_c     = shift_nxt_c[ADDR_FIELD_W-1:0];
  assign wr_addr_c     = shift_nxt_c[ADDR_LSB +: ADDR_FIELD_W];
  assign rd_data_c     = addr_in_range(rd_addr_c, NADDRBITS) ?
                         regs_q[rd_addr_c[NADDRBITS-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state and per-cycle frame actions; chip-select edges override everything
  always_comb begin
    state_d  = state;
    start_c  = 1'b0;
    stop_c   = 1'b0;
    sample_c = 1'b0;
    shift_c  = 1'b0;
    load_c   = 1'b0;
    last_c   = 1'b0;
    write_c  = 1'b0;
    case (state)
      ST_SHIFT: begin
        sample_c = sample_edge_c;
        shift_c  = shift_edge_c & miso_oe;
        load_c   = sample_edge_c & (bit_cnt == CNTW'(CMD_BITS - 1)) &
                   shift_nxt_c[CMD_BITS-1];
        last_c   = sample_edge_c & (bit_cnt == CNTW'(FLEN - 1));
        write_c  = last_c & ~shift_nxt_c[RNW_BIT] &
                   addr_in_range(wr_addr_c, NADDRBITS);
        if (last_c) state_d = ST_DONE;
      end
      ST_IDLE, ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (cs_rise_c) begin
      state_d = ST_IDLE;
      stop_c  = 1'b1;
    end else if (cs_fall_c) begin
      state_d = ST_SHIFT;
      start_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      out_sr  <= '0;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
    end else if (start_c) begin
      bit_cnt <= '0;
      shreg   <= '0;
      out_sr  <= '0;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
    end else if (stop_c) begin
      miso    <= 1'b0;
      miso_oe <= 1'b0;
    end else begin
      if (sample_c) begin
        shreg   <= shift_nxt_c[FLEN-2:0];
        bit_cnt <= bit_cnt + CNTW'(1);
      end
      if (load_c) begin
        out_sr  <= rd_data_c;
        miso_oe <= 1'b1;
      end
      if (shift_c) begin
        miso   <= out_sr[NDATABITS-1];
        out_sr <= {out_sr[NDATABITS-2:0], 1'b0};
      end
      // Overlong frames read back zeros
      if (last_c) miso <= 1'b0;
    end
  end

  // Frame commit: register write, strobe and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      wr_stb_o    <= 1'b0;
      wr_addr_o   <= '0;
      frame_cnt_o <= '0;
    end else begin
      wr_stb_o <= write_c;
      if (last_c) frame_cnt_o <= frame_cnt_o + 16'd1;
      if (write_c) begin
        regs_q[wr_addr_c[NADDRBITS-1:0]] <= shift_nxt_c[NDATABITS-1:0];
        wr_addr_o <= wr_addr_c[NADDRBITS-1:0];
      end
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_o[k*NDATABITS +: NDATABITS] = regs_q[k];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: one instance per clock polarity,
// driven as an SPI master at sclk = clk/8 and compared with a register model.
module tb_spi_slave_regfile;

  localparam int unsigned NA = 3;
  localparam int unsigned ND = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned FL = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic mosi  = 1'b0;
  logic sclk0 = 1'b0;
  logic cs_n0 = 1'b1;
  logic sclk1 = 1'b1;
  logic cs_n1 = 1'b1;
  logic miso0, oe0, stb0, miso1, oe1, stb1;
  logic [NR*ND-1:0] regs0, regs1;
  logic [NA-1:0]    waddr0, waddr1;
  logic [15:0]      fcnt0, fcnt1;

  int checks   = 0;
  int failures = 0;
  int stb_cnt [2];
  logic [NA-1:0] stb_addr [2];

  logic [ND-1:0] mreg [2][NR];
  int            mcnt [2];
  int            mstb [2];
  logic [NA-1:0] maddr [2];
  logic [39:0]   oe_v, mi_v;

  spi_slave_regfile #(.NADDRBITS(NA), .NDATABITS(ND), .INVERT_CLOCK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .regs_o(regs0), .wr_stb_o(stb0),
    .wr_addr_o(waddr0), .frame_cnt_o(fcnt0)
  );

  spi_slave_regfile #(.NADDRBITS(NA), .NDATABITS(ND), .INVERT_CLOCK(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .regs_o(regs1), .wr_stb_o(stb1),
    .wr_addr_o(waddr1), .frame_cnt_o(fcnt1)
  );

  always #5 clk = ~clk;

  // Strobe monitor: every high cycle counts, so a stretched pulse shows up
  always @(negedge clk) begin
    if (stb0) begin stb_cnt[0]++; stb_addr[0] = waddr0; end
    if (stb1) begin stb_cnt[1]++; stb_addr[1] = waddr1; end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv_sclk(input int d, input logic v);
    if (d == 1) sclk1 = v; else sclk0 = v;
  endtask

  task automatic drv_cs(input int d, input logic v);
    if (d == 1) cs_n1 = v; else cs_n0 = v;
  endtask

  function automatic logic rd_miso(input int d);
    return (d == 1) ? miso1 : miso0;
  endfunction

  function automatic logic rd_oe(input int d);
    return (d == 1) ? oe1 : oe0;
  endfunction

  function automatic logic [NR*ND-1:0] model_flat(input int d);
    logic [NR*ND-1:0] v;
    for (int k = 0; k < NR; k++) v[k*ND +: ND] = mreg[d][k];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      for (int k = 0; k < NR; k++) mreg[d][k] = '0;
    end
  endtask

  // Clock n bits MSB first; master samples miso just before each sample edge
  task automatic shift_bits(input int d, input logic [FL-1:0] w, input int n);
    logic idle;
    idle = (d == 1);
    oe_v = '0;
    mi_v = '0;
    for (int i = 0; i < n; i++) begin
      if (i < FL) mosi = w[FL-1-i];
      else        mosi = 1'($urandom);
      drv_sclk(d, idle);
      wait_clk(4);
      oe_v[i] = rd_oe(d);
      mi_v[i] = rd_miso(d);
      drv_sclk(d, ~idle);
      wait_clk(4);
    end
    drv_sclk(d, idle);
    wait_clk(4);
  endtask

  task automatic run_frame(input int d, input logic [FL-1:0] w, input int n, input string tag);
    logic          rnw, ok, complete;
    logic [6:0]    a;
    logic [ND-1:0] exp_rd;
    logic [39:0]   eoe, emi;
    logic [1:0]    end_st;
    int            stb_before;
    rnw        = w[FL-1];
    a          = w[FL-2 -: 7];
    ok         = (int'(a) < NR);
    exp_rd     = (rnw && ok) ? mreg[d][a[NA-1:0]] : '0;
    complete   = (n >= FL);
    stb_before = mstb[d];
    eoe = '0;
    emi = '0;
    for (int i = 0; i < n; i++) begin
      eoe[i] = rnw && (i >= 8);
      if (rnw && i >= 8 && i < FL) emi[i] = exp_rd[FL-1-i];
    end

    drv_cs(d, 1'b0);
    wait_clk(6);
    shift_bits(d, w, n);
    drv_cs(d, 1'b1);
    wait_clk(4);
    end_st = {rd_oe(d), rd_miso(d)};
    wait_clk(4);

    if (complete) begin
      mcnt[d]++;
      if (!rnw && ok) begin
        mreg[d][a[NA-1:0]] = w[ND-1:0];
        mstb[d]++;
        maddr[d] = a[NA-1:0];
      end
    end

    chk({tag, ":regs"}, 128'((d == 1) ? regs1 : regs0), 128'(model_flat(d)));
    chk({tag, ":frame_cnt"}, 128'((d == 1) ? fcnt1 : fcnt0), 128'(16'(mcnt[d])));
    chk({tag, ":stb_cnt"}, 128'(stb_cnt[d]), 128'(mstb[d]));
    if (mstb[d] != stb_before)
      chk({tag, ":stb_addr"}, 128'(stb_addr[d]), 128'(maddr[d]));
    chk({tag, ":miso_oe_bits"}, 128'(oe_v), 128'(eoe));
    chk({tag, ":miso_bits"}, 128'(mi_v), 128'(emi));
    chk({tag, ":after_cs"}, 128'(end_st), 128'(0));
  endtask

  initial begin
    logic [FL-1:0] w;
    int            n;
    stb_cnt[0] = 0;
    stb_cnt[1] = 0;
    mstb[0] = 0;
    mstb[1] = 0;
    maddr[0] = '0;
    maddr[1] = '0;
    model_reset();

    rst_n = 1'b0;
    wait_clk(3);
    chk("reset:regs0", 128'(regs0), 128'(0));
    chk("reset:ctl0", 128'({fcnt0, miso0, oe0, stb0}), 128'(0));
    chk("reset:ctl1", 128'({regs1, fcnt1, miso1, oe1, stb1}), 128'(0));
    rst_n = 1'b1;
    wait_clk(5);

    run_frame(0, 24'h03ABCD, 24, "write_reg3");
    run_frame(0, 24'h830000, 24, "read_reg3");
    run_frame(0, 24'h0100C3, 24, "write_reg1");
    run_frame(0, 24'h011234, 20, "abort_reg1");
    run_frame(0, 24'h10FFFF, 24, "write_oor");
    run_frame(0, 24'h900000, 24, "read_oor");
    run_frame(0, 24'h810000, 24, "read_reg1");

    for (int j = 0; j < 12; j++) begin
      w = {1'($urandom), 7'($urandom_range(0, 11)), 16'($urandom)};
      if (j % 4 == 3)      n = int'($urandom_range(9, 23));
      else if (j % 4 == 2) n = 27;
      else                 n = 24;
      run_frame(j % 2, w, n, "random");
    end

    // Reset in the middle of a write frame
    drv_cs(0, 1'b0);
    wait_clk(6);
    shift_bits(0, 24'h057777, 12);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst:regs0", 128'(regs0), 128'(model_flat(0)));
    chk("midrst:ctl0", 128'({fcnt0, miso0, oe0, stb0}), 128'(0));
    chk("midrst:regs1", 128'(regs1), 128'(model_flat(1)));
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    // cs_n still low after reset release: no frame may start
    shift_bits(0, 24'h025A5A, 24);
    chk("cs_held:regs0", 128'(regs0), 128'(model_flat(0)));
    chk("cs_held:frame_cnt", 128'(fcnt0), 128'(16'(mcnt[0])));
    drv_cs(0, 1'b1);
    wait_clk(6);
    run_frame(0, 24'h025A5A, 24, "post_rst_write");
    run_frame(0, 24'h820000, 24, "post_rst_read");

    run_frame(1, 24'h04BEEF, 30, "inv_long_write");
    run_frame(1, 24'h840000, 30, "inv_long_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
